// File: rtl/request_unit.sv
// request_unit: multi-cycle fetch / execute / memory sequencer with one outstanding request.
// Optional performance counters are enabled by defining REQUEST_UNIT_PERF_EN.
`timescale 1ns/1ps
module request_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        ihit,
  input  logic [31:0] iload,
  input  logic        dhit,
  input  logic [31:0] dload,
  input  logic        MemRd,
  input  logic        MemWr,
  input  logic        Halt,
  input  logic [31:0] alu_addr,
  input  logic [31:0] store_data,
  input  logic [31:0] next_pc,
  output logic        iREN,
  output logic [31:0] iaddr,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] daddr,
  output logic [31:0] dstore,
  output logic [31:0] Instr,
  output logic        exec,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic [31:0] pc,
  output logic        halted,
`ifdef REQUEST_UNIT_PERF_EN
  output logic [31:0] instr_count,
  output logic [31:0] stall_count,
`endif
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    EXEC   = 2'd1,
    MEM    = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t      state_q;
  logic        is_write_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] daddr_q;
  logic [31:0] dstore_q;
  logic [31:0] npc_q;
  logic [31:0] load_data_q;
  logic        load_valid_q;

  // Handshake: a request (iREN, dREN or dWEN) is held with a stable address
  // until the matching hit; hits are ignored when their request is low.
  always_ff @(posedge clk) begin
    if (n_rst) begin
      state_q      <= FETCH;
      is_write_q   <= 1'b0;
      pc_q         <= RESET_PC;
      instr_q      <= 32'h0;
      daddr_q      <= 32'h0;
      dstore_q     <= 32'h0;
      npc_q        <= 32'h0;
      load_data_q  <= 32'h0;
      load_valid_q <= 1'b0;
    end else begin
      load_valid_q <= 1'b0;
      case (state_q)
        FETCH: begin
          if (ihit) begin
            instr_q <= iload;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          if (Halt) begin
            state_q <= HALTED;
          end else if (MemWr) begin
            // MemRd alongside MemWr is deliberately treated as a plain write
            is_write_q <= 1'b1;
            daddr_q    <= alu_addr;
            dstore_q   <= store_data;
            npc_q      <= next_pc;
            state_q    <= MEM;
          end else if (MemRd) begin
            is_write_q <= 1'b0;
            daddr_q    <= alu_addr;
            npc_q      <= next_pc;
            state_q    <= MEM;
          end else begin
            pc_q    <= next_pc;
            state_q <= FETCH;
          end
        end
        MEM: begin
          if (dhit) begin
            pc_q    <= npc_q;
            state_q <= FETCH;
            if (!is_write_q) begin
              load_data_q  <= dload;
              load_valid_q <= 1'b1;
            end
          end
        end
        HALTED: begin
          state_q <= HALTED;
        end
        default: state_q <= FETCH;
      endcase
    end
  end

`ifdef REQUEST_UNIT_PERF_EN
  logic [31:0] instr_count_q;
  logic [31:0] stall_count_q;

  always_ff @(posedge clk) begin
    if (n_rst) begin
      instr_count_q <= 32'h0;
      stall_count_q <= 32'h0;
    end else begin
      if (state_q == EXEC) begin
        instr_count_q <= instr_count_q + 32'd1;
      end
      if ((state_q == FETCH && !ihit) || (state_q == MEM && !dhit)) begin
        stall_count_q <= stall_count_q + 32'd1;
      end
    end
  end

  assign instr_count = instr_count_q;
  assign stall_count = stall_count_q;
`endif

  // Every output is a register or a decode of state_q, so no hit input
  // reaches an output combinationally.
  assign iREN        = (state_q == FETCH);
  assign exec        = (state_q == EXEC);
  assign dREN        = (state_q == MEM) && !is_write_q;
  assign dWEN        = (state_q == MEM) && is_write_q;
  assign halted      = (state_q == HALTED);
  assign iaddr       = pc_q;
  assign pc          = pc_q;
  assign Instr       = instr_q;
  assign daddr       = daddr_q;
  assign dstore      = dstore_q;
  assign load_data   = load_data_q;
  assign load_valid  = load_valid_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_request_unit.sv
// Directed testbench for request_unit with RESET_PC = 32'h200.
// Perf counter checks are compiled in when REQUEST_UNIT_PERF_EN is defined.
`timescale 1ns/1ps
module tb_request_unit;

  logic        clk;
  logic        n_rst;
  logic        ihit;
  logic [31:0] iload;
  logic        dhit;
  logic [31:0] dload;
  logic        MemRd, MemWr, Halt;
  logic [31:0] alu_addr, store_data, next_pc;
  logic        iREN, dREN, dWEN, exec, load_valid, halted;
  logic [31:0] iaddr, daddr, dstore, Instr, load_data, pc;
  logic [1:0]  dbg_state;
`ifdef REQUEST_UNIT_PERF_EN
  logic [31:0] instr_count, stall_count;
`endif

  int n_cmp;
  int n_fail;

  request_unit #(.RESET_PC(32'h0000_0200)) dut (
    .clk(clk), .n_rst(n_rst), .ihit(ihit), .iload(iload), .dhit(dhit), .dload(dload),
    .MemRd(MemRd), .MemWr(MemWr), .Halt(Halt), .alu_addr(alu_addr),
    .store_data(store_data), .next_pc(next_pc),
    .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .Instr(Instr), .exec(exec), .load_data(load_data), .load_valid(load_valid),
    .pc(pc), .halted(halted),
`ifdef REQUEST_UNIT_PERF_EN
    .instr_count(instr_count), .stall_count(stall_count),
`endif
    .dbg_state_o(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; outputs are then sampled 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pull one instruction in with an immediate hit; leaves the unit in EXEC.
  task automatic fetch_instr(input logic [31:0] word);
    ihit  = 1'b1;
    iload = word;
    step();
    ihit  = 1'b0;
  endtask

  task automatic test_reset();
    n_rst = 1'b1; ihit = 1'b0; dhit = 1'b0; iload = 32'h0; dload = 32'h0;
    MemRd = 1'b0; MemWr = 1'b0; Halt = 1'b0;
    alu_addr = 32'h0; store_data = 32'h0; next_pc = 32'h0;
    step();
    step();
    n_rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      n_cmp++; if (iREN !== 1'b1) begin n_fail++; $display("FAIL reset_iren c%0d: got %b want 1", c, iREN); end
      n_cmp++; if (iaddr !== 32'h200) begin n_fail++; $display("FAIL reset_iaddr c%0d: got %h want 00000200", c, iaddr); end
      n_cmp++; if (exec !== 1'b0 || halted !== 1'b0) begin n_fail++; $display("FAIL reset_exec_halt c%0d: got %b%b want 00", c, exec, halted); end
      n_cmp++; if (dREN !== 1'b0 || dWEN !== 1'b0) begin n_fail++; $display("FAIL reset_dreq c%0d: got %b%b want 00", c, dREN, dWEN); end
      if (c < 2) step();
    end
    n_cmp++; if (Instr !== 32'h0 || daddr !== 32'h0 || dstore !== 32'h0) begin n_fail++; $display("FAIL reset_regs: got %h %h %h want zeros", Instr, daddr, dstore); end
    n_cmp++; if (load_data !== 32'h0 || load_valid !== 1'b0) begin n_fail++; $display("FAIL reset_load: got %h %b want 0 0", load_data, load_valid); end
  endtask

  task automatic test_alu();
    next_pc = 32'h204;
    fetch_instr(32'h0022_1820);
    n_cmp++; if (exec !== 1'b1) begin n_fail++; $display("FAIL alu_exec: got %b want 1", exec); end
    n_cmp++; if (Instr !== 32'h0022_1820) begin n_fail++; $display("FAIL alu_instr: got %h want 00221820", Instr); end
    n_cmp++; if (iREN !== 1'b0 || dREN !== 1'b0 || dWEN !== 1'b0) begin n_fail++; $display("FAIL alu_exec_reqs: got %b%b%b want 000", iREN, dREN, dWEN); end
    n_cmp++; if (pc !== 32'h200) begin n_fail++; $display("FAIL alu_pc_exec: got %h want 00000200", pc); end
    step();
    n_cmp++; if (exec !== 1'b0 || iREN !== 1'b1) begin n_fail++; $display("FAIL alu_back_fetch: got exec=%b iREN=%b want 0 1", exec, iREN); end
    n_cmp++; if (pc !== 32'h204 || iaddr !== 32'h204) begin n_fail++; $display("FAIL alu_pc: got %h/%h want 00000204", pc, iaddr); end
    n_cmp++; if (dREN !== 1'b0 || dWEN !== 1'b0) begin n_fail++; $display("FAIL alu_dreq: got %b%b want 00", dREN, dWEN); end
`ifdef REQUEST_UNIT_PERF_EN
    n_cmp++; if (instr_count !== 32'd1 || stall_count !== 32'd2) begin n_fail++; $display("FAIL perf_counts: got %0d/%0d want 1/2", instr_count, stall_count); end
`endif
  endtask

  task automatic test_load();
    int pulses;
    pulses = 0;
    fetch_instr(32'h8C22_0000);
    MemRd = 1'b1; alu_addr = 32'h1000; next_pc = 32'h208;
    step();
    MemRd = 1'b0; alu_addr = 32'hFFFF_0000;
    for (int c = 0; c < 3; c++) begin
      n_cmp++; if (dREN !== 1'b1 || dWEN !== 1'b0) begin n_fail++; $display("FAIL load_dreq c%0d: got %b%b want 10", c, dREN, dWEN); end
      n_cmp++; if (iREN !== 1'b0) begin n_fail++; $display("FAIL load_overlap c%0d: got iREN=%b want 0", c, iREN); end
      n_cmp++; if (daddr !== 32'h1000) begin n_fail++; $display("FAIL load_daddr c%0d: got %h want 00001000", c, daddr); end
      n_cmp++; if (pc !== 32'h204) begin n_fail++; $display("FAIL load_pc_wait c%0d: got %h want 00000204", c, pc); end
      if (c == 2) begin dhit = 1'b1; dload = 32'hDEAD_BEEF; end
      if (load_valid) pulses++;
      step();
    end
    dhit = 1'b0; dload = 32'h0;
    n_cmp++; if (load_valid !== 1'b1) begin n_fail++; $display("FAIL load_valid: got %b want 1", load_valid); end
    n_cmp++; if (load_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL load_data: got %h want deadbeef", load_data); end
    n_cmp++; if (iREN !== 1'b1 || dREN !== 1'b0 || pc !== 32'h208) begin n_fail++; $display("FAIL load_done: got iREN=%b dREN=%b pc=%h want 1 0 00000208", iREN, dREN, pc); end
    if (load_valid) pulses++;
    step();
    if (load_valid) pulses++;
    n_cmp++; if (pulses != 1) begin n_fail++; $display("FAIL load_pulses: got %0d want 1", pulses); end
    n_cmp++; if (load_data !== 32'hDEAD_BEEF || iREN !== 1'b1) begin n_fail++; $display("FAIL load_hold: got %h iREN=%b want deadbeef 1", load_data, iREN); end
  endtask

  task automatic test_store();
    fetch_instr(32'hAC22_0000);
    MemRd = 1'b1; MemWr = 1'b1; alu_addr = 32'h2000; store_data = 32'h1234; next_pc = 32'h20C;
    step();
    MemRd = 1'b0; MemWr = 1'b0; alu_addr = 32'h5555_5555; store_data = 32'hAAAA_AAAA;
    n_cmp++; if (dWEN !== 1'b1 || dREN !== 1'b0) begin n_fail++; $display("FAIL store_dreq: got dWEN=%b dREN=%b want 1 0", dWEN, dREN); end
    n_cmp++; if (dstore !== 32'h1234 || daddr !== 32'h2000) begin n_fail++; $display("FAIL store_latch: got %h @%h want 00001234 @00002000", dstore, daddr); end
    step();
    n_cmp++; if (dstore !== 32'h1234 || daddr !== 32'h2000 || dWEN !== 1'b1) begin n_fail++; $display("FAIL store_stable: got %h @%h dWEN=%b", dstore, daddr, dWEN); end
    n_cmp++; if (pc !== 32'h208) begin n_fail++; $display("FAIL store_pc_wait: got %h want 00000208", pc); end
    dhit = 1'b1;
    step();
    dhit = 1'b0;
    n_cmp++; if (pc !== 32'h20C || dWEN !== 1'b0 || iREN !== 1'b1) begin n_fail++; $display("FAIL store_done: got pc=%h dWEN=%b iREN=%b want 0000020c 0 1", pc, dWEN, iREN); end
    n_cmp++; if (load_valid !== 1'b0) begin n_fail++; $display("FAIL store_no_load: got %b want 0", load_valid); end
  endtask

  task automatic test_halt();
    fetch_instr(32'hFFFF_FFFF);
    Halt = 1'b1; next_pc = 32'h999;
    step();
    Halt = 1'b0;
    for (int c = 0; c < 10; c++) begin
      n_cmp++; if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_flag c%0d: got %b want 1", c, halted); end
      n_cmp++; if (iREN !== 1'b0 || dREN !== 1'b0 || dWEN !== 1'b0 || exec !== 1'b0) begin n_fail++; $display("FAIL halt_reqs c%0d: got %b%b%b%b want 0000", c, iREN, dREN, dWEN, exec); end
      n_cmp++; if (pc !== 32'h20C || Instr !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL halt_frozen c%0d: got pc=%h Instr=%h", c, pc, Instr); end
      ihit = c[0]; dhit = ~c[0]; iload = 32'h1111_0000 + c; MemRd = c[1]; MemWr = c[2];
      step();
    end
    ihit = 1'b0; dhit = 1'b0; MemRd = 1'b0; MemWr = 1'b0;
    n_rst = 1'b1;
    step();
    n_rst = 1'b0;
    n_cmp++; if (halted !== 1'b0 || iREN !== 1'b1 || pc !== 32'h200) begin n_fail++; $display("FAIL halt_exit: got halted=%b iREN=%b pc=%h want 0 1 00000200", halted, iREN, pc); end
    n_cmp++; if (Instr !== 32'h0) begin n_fail++; $display("FAIL halt_exit_instr: got %h want 0", Instr); end
  endtask

  task automatic test_reset_in_mem();
    dhit = 1'b1;
    step();
    n_cmp++; if (iREN !== 1'b1) begin n_fail++; $display("FAIL fetch_ignores_dhit: got iREN=%b want 1", iREN); end
    dhit = 1'b0;
    fetch_instr(32'h8C33_0000);
    MemRd = 1'b1; alu_addr = 32'h3000; next_pc = 32'h204;
    step();
    MemRd = 1'b0;
    n_cmp++; if (dREN !== 1'b1) begin n_fail++; $display("FAIL rmem_dren: got %b want 1", dREN); end
    step();
    n_rst = 1'b1; dhit = 1'b1; dload = 32'h7777_7777;
    step();
    n_rst = 1'b0; dhit = 1'b0;
    n_cmp++; if (dREN !== 1'b0 || dWEN !== 1'b0) begin n_fail++; $display("FAIL rmem_dreq: got %b%b want 00", dREN, dWEN); end
    n_cmp++; if (pc !== 32'h200 || iREN !== 1'b1) begin n_fail++; $display("FAIL rmem_pc: got %h iREN=%b want 00000200 1", pc, iREN); end
    n_cmp++; if (load_valid !== 1'b0 || load_data !== 32'h0) begin n_fail++; $display("FAIL rmem_load: got %b %h want 0 0", load_valid, load_data); end
`ifdef REQUEST_UNIT_PERF_EN
    n_cmp++; if (instr_count !== 32'd0 || stall_count !== 32'd0) begin n_fail++; $display("FAIL rmem_perf: got %0d/%0d want 0/0", instr_count, stall_count); end
`endif
  endtask

  task automatic test_back_to_back_wrap();
    ihit = 1'b1; iload = 32'h0000_0001; next_pc = 32'hFFFF_FFFC;
    step();
    step();
    n_cmp++; if (pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_hi: got %h want fffffffc", pc); end
    iload = 32'h0000_0002; next_pc = 32'h0000_0000;
    step();
    n_cmp++; if (exec !== 1'b1 || Instr !== 32'h0000_0002) begin n_fail++; $display("FAIL b2b_exec: got exec=%b Instr=%h want 1 00000002", exec, Instr); end
    step();
    ihit = 1'b0;
    n_cmp++; if (pc !== 32'h0 || iaddr !== 32'h0) begin n_fail++; $display("FAIL wrap_lo: got %h want 00000000", pc); end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_halt();
    test_reset_in_mem();
    test_back_to_back_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/request_unit.md
# request_unit

Multi-cycle memory request sequencer between the decoder and the instruction/data memory ports; it issues the read requests whose results the decoder consumes. It fetches an instruction word, presents it to decode for one execute cycle, then issues a data read or write when the decoded instruction asks for one, and advances the PC. It guarantees at most one outstanding memory request at a time and latches a sticky halt.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- clk  in  1  rising-edge clock
- n_rst  in  1  synchronous, active-high reset (n_rst=1 at a rising edge resets); the port keeps the codebase reset name
- ihit  in  1  instruction memory read complete this cycle
- iload  in  32  instruction word, valid when ihit=1
- dhit  in  1  data memory access complete this cycle
- dload  in  32  load data, valid when dhit=1 and dREN=1
- MemRd, MemWr, Halt  in  1 each  decoded controls for Instr
- alu_addr  in  32  effective data address from datapath
- store_data  in  32  register value to store
- next_pc  in  32  PC successor computed by datapath (branch/jump resolved)
- iREN  out  1  instruction read request
- iaddr  out  32  instruction address (= pc)
- dREN, dWEN  out  1 each  data read / write request
- daddr, dstore  out  32 each  latched data address / store data
- Instr  out  32  latched instruction to decoder
- exec  out  1  high in the single execute cycle; datapath commits register writes only when exec=1 (loads: when load_valid=1)
- load_data  out  32  captured load word
- load_valid  out  1  one-cycle pulse, load_data valid
- pc  out  32  current PC
- halted  out  1  sticky halt

## Operation
- States: FETCH, EXEC, MEM, HALTED. Reset state FETCH.
- FETCH: iREN=1, iaddr=pc. On ihit: Instr<=iload, ->EXEC. No ihit: stay.
- EXEC: exec=1, no requests. Priority: Halt -> HALTED (pc unchanged); else MemWr -> latch daddr<=alu_addr, dstore<=store_data, ->MEM as write; else MemRd -> latch daddr, ->MEM as read; else pc<=next_pc, ->FETCH.
- MemRd and MemWr both high: treated as write; dREN stays 0.
- next_pc sampled in EXEC for memory instructions too (held in a register), applied to pc on dhit.
- MEM: dWEN or dREN=1 with stable daddr/dstore. On dhit: pc<=saved next_pc, ->FETCH; read: load_data<=dload, load_valid=1 next cycle (first FETCH cycle).
- HALTED: all requests 0, halted=1, Instr/pc frozen; only reset exits.
- Invariant: iREN and (dREN|dWEN) never both 1; dREN and dWEN never both 1.
- hit inputs ignored in states where the matching request is deasserted.

## Timing
- Reset values: pc=RESET_PC, Instr=0, daddr=0, dstore=0, load_data=0, load_valid=0, exec=0, halted=0, dREN=dWEN=0; iREN=1 in first post-reset cycle (FETCH).
- Reset dominates every state; request deasserted at the resetting edge, in-flight hit discarded.
- All outputs registered or decoded from state register only; no combinational path from ihit/dhit to any output.
- Latency with hit in first request cycle: ALU instruction 2 cycles; load/store 3 cycles; load_valid 1 cycle after dhit.
- Request stays asserted with unchanged address until its hit; no cancellation.
- pc arithmetic: 32-bit, wraps 32'hFFFF_FFFC -> next_pc as supplied (no internal increment).

## Configuration
- REQUEST_UNIT_PERF_EN defined: adds outputs instr_count[31:0] (increments per EXEC cycle) and stall_count[31:0] (increments per FETCH/MEM cycle without hit); both reset to 0, wrap modulo 2^32, freeze in HALTED.
- Undefined: ports and counters absent; all other behaviour identical.

## Test plan
- Reset with RESET_PC=32'h0000_0200, ihit=0 for 3 cycles -> iREN=1, iaddr=32'h200 held 3 cycles, exec=0, halted=0.
- ADD fetched (iload=32'h0022_1820, ihit immediate), next_pc=32'h204 -> exec pulse cycle 2, pc=32'h204, iREN=1 cycle 3, dREN=dWEN=0 throughout.
- LW, alu_addr=32'h1000, dhit after 2 wait cycles, dload=32'hDEAD_BEEF -> dREN=1 for 3 cycles, daddr=32'h1000, load_data=32'hDEADBEEF with one load_valid pulse, iREN never overlaps dREN.
- SW with MemRd=MemWr=1, store_data=32'h1234 -> dWEN=1, dREN=0, dstore=32'h1234, pc updates on dhit.
- Halt in EXEC, then ihit/dhit toggled 10 cycles -> halted=1, all requests 0, pc unchanged; n_rst=1 -> FETCH at RESET_PC.
- n_rst asserted in MEM mid-wait -> dREN/dWEN=0 next cycle, pc=RESET_PC; with REQUEST_UNIT_PERF_EN, counters read 0.
